// File: rtl/rob_commit.sv
// rtl/rob_commit.sv - in-order retirement buffer with completion ports, commit and flush
//
// Purpose: circular reorder buffer. Issue allocates entries at the tail, RS/SLB
// completions mark entries ready, and the head retires one entry per cycle in
// program order. A mispredicted branch or JALR retires and raises Clear_flag,
// which empties the whole buffer on the following enabled edge.
//
// Ports:
//   clk, rst, rdy                       clock, sync active-high reset, global enable
//   alloc_valid/kind/rd/pred_taken/target   allocation request
//   alloc_tag, rob_full                 tail tag and full status (from registered state)
//   rs_valid/tag/value, rs_jump_valid/jumppc   RS completion (plus JALR target)
//   slb_valid/tag/value                 SLB completion
//   commit_valid/tag/value/rd/store     registered retirement outputs
//   Clear_flag, redirect_pc             flush pulse and fetch redirect target
module rob_commit #(
   parameter int ROB_DEPTH = 16,
   parameter int DATA_W    = 32,
   localparam int TAG_W    = $clog2(ROB_DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              alloc_valid,
   input  logic [1:0]        alloc_kind,
   input  logic [4:0]        alloc_rd,
   input  logic              alloc_pred_taken,
   input  logic [DATA_W-1:0] alloc_target,
   output logic [TAG_W-1:0]  alloc_tag,
   output logic              rob_full,
   input  logic              rs_valid,
   input  logic [TAG_W-1:0]  rs_tag,
   input  logic [DATA_W-1:0] rs_value,
   input  logic              rs_jump_valid,
   input  logic [DATA_W-1:0] rs_jumppc,
   input  logic              slb_valid,
   input  logic [TAG_W-1:0]  slb_tag,
   input  logic [DATA_W-1:0] slb_value,
   output logic              commit_valid,
   output logic [TAG_W-1:0]  commit_tag,
   output logic [DATA_W-1:0] commit_value,
   output logic [4:0]        commit_rd,
   output logic              commit_store,
   output logic              Clear_flag,
   output logic [DATA_W-1:0] redirect_pc
);

   localparam logic [1:0] KIND_REG    = 2'd0;
   localparam logic [1:0] KIND_BRANCH = 2'd1;
   localparam logic [1:0] KIND_JALR   = 2'd2;
   localparam logic [1:0] KIND_STORE  = 2'd3;
   localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(ROB_DEPTH);

   logic [TAG_W-1:0]  head, tail;
   logic [TAG_W:0]    count;

   logic              busy   [ROB_DEPTH];
   logic              ready  [ROB_DEPTH];
   logic [1:0]        kind   [ROB_DEPTH];
   logic [4:0]        rd     [ROB_DEPTH];
   logic              pred   [ROB_DEPTH];
   logic [DATA_W-1:0] target [ROB_DEPTH];
   logic [DATA_W-1:0] value  [ROB_DEPTH];
   logic [DATA_W-1:0] jumppc [ROB_DEPTH];

   logic              do_commit, do_alloc, mispredict;
   logic [DATA_W-1:0] mis_pc;

   assign alloc_tag = tail;
   assign rob_full  = (count == FULL_CNT);

   // Everything is frozen during the flush cycle, so Clear_flag gates both paths.
   assign do_commit = busy[head] && ready[head] && !Clear_flag;
   assign do_alloc  = alloc_valid && !rob_full && !Clear_flag;

   always_comb begin
      mispredict = 1'b0;
      mis_pc     = target[head];
      case (kind[head])
         KIND_BRANCH: begin
            mispredict = (value[head][0] != pred[head]);
            mis_pc     = target[head];
         end
         KIND_JALR: begin
            mispredict = (jumppc[head] != target[head]);
            mis_pc     = jumppc[head];
         end
         default: begin
            mispredict = 1'b0;
            mis_pc     = target[head];
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head         <= '0;
         tail         <= '0;
         count        <= '0;
         commit_valid <= 1'b0;
         commit_store <= 1'b0;
         Clear_flag   <= 1'b0;
         commit_tag   <= '0;
         commit_value <= '0;
         commit_rd    <= '0;
         redirect_pc  <= '0;
         for (int i = 0; i < ROB_DEPTH; i++) begin
            busy[i]  <= 1'b0;
            ready[i] <= 1'b0;
         end
      end else if (rdy) begin
         if (Clear_flag) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            commit_valid <= 1'b0;
            commit_store <= 1'b0;
            Clear_flag   <= 1'b0;
            for (int i = 0; i < ROB_DEPTH; i++) begin
               busy[i]  <= 1'b0;
               ready[i] <= 1'b0;
            end
         end else begin
            commit_valid <= do_commit;
            commit_store <= do_commit && (kind[head] == KIND_STORE);
            Clear_flag   <= do_commit && mispredict;
            if (do_commit) begin
               commit_tag   <= head;
               commit_value <= value[head];
               commit_rd    <= rd[head];
               if (mispredict)
                  redirect_pc <= mis_pc;
            end

            // SLB is written first so an RS write to the same tag overrides it.
            if (slb_valid && busy[slb_tag]) begin
               value[slb_tag] <= slb_value;
               ready[slb_tag] <= 1'b1;
            end
            if (rs_valid && busy[rs_tag]) begin
               value[rs_tag] <= rs_value;
               ready[rs_tag] <= 1'b1;
               if (rs_jump_valid)
                  jumppc[rs_tag] <= rs_jumppc;
            end

            // Tail never equals a busy head here: alloc requires not full.
            if (do_alloc) begin
               busy[tail]   <= 1'b1;
               ready[tail]  <= 1'b0;
               kind[tail]   <= alloc_kind;
               rd[tail]     <= alloc_rd;
               pred[tail]   <= alloc_pred_taken;
               target[tail] <= alloc_target;
            end

            if (do_commit)
               busy[head] <= 1'b0;

            tail  <= tail + TAG_W'(do_alloc);
            head  <= head + TAG_W'(do_commit);
            count <= count + (TAG_W+1)'(do_alloc) - (TAG_W+1)'(do_commit);
         end
      end
   end

endmodule

// File: tb/tb_rob_commit.sv
// tb/tb_rob_commit.sv - self-checking bench for rob_commit
module tb_rob_commit;

   logic        clk = 1'b0;
   logic        rst, rdy;
   logic        alloc_valid;
   logic [1:0]  alloc_kind;
   logic [4:0]  alloc_rd;
   logic        alloc_pred_taken;
   logic [31:0] alloc_target;
   logic [3:0]  alloc_tag;
   logic        rob_full;
   logic        rs_valid;
   logic [3:0]  rs_tag;
   logic [31:0] rs_value;
   logic        rs_jump_valid;
   logic [31:0] rs_jumppc;
   logic        slb_valid;
   logic [3:0]  slb_tag;
   logic [31:0] slb_value;
   logic        commit_valid;
   logic [3:0]  commit_tag;
   logic [31:0] commit_value;
   logic [4:0]  commit_rd;
   logic        commit_store;
   logic        Clear_flag;
   logic [31:0] redirect_pc;

   rob_commit dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .alloc_valid(alloc_valid), .alloc_kind(alloc_kind), .alloc_rd(alloc_rd),
      .alloc_pred_taken(alloc_pred_taken), .alloc_target(alloc_target),
      .alloc_tag(alloc_tag), .rob_full(rob_full),
      .rs_valid(rs_valid), .rs_tag(rs_tag), .rs_value(rs_value),
      .rs_jump_valid(rs_jump_valid), .rs_jumppc(rs_jumppc),
      .slb_valid(slb_valid), .slb_tag(slb_tag), .slb_value(slb_value),
      .commit_valid(commit_valid), .commit_tag(commit_tag), .commit_value(commit_value),
      .commit_rd(commit_rd), .commit_store(commit_store),
      .Clear_flag(Clear_flag), .redirect_pc(redirect_pc)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: program-ordered queue of in-flight instructions.
   typedef struct {
      logic [3:0]  tag;
      logic [1:0]  kind;
      logic [4:0]  rd;
      logic        pred;
      logic [31:0] target;
      logic [31:0] value;
      logic [31:0] jumppc;
      logic        ready;
   } ent_t;

   ent_t        q[$];
   logic [3:0]  m_tail = 0;
   logic        m_cv = 0, m_cst = 0, m_clr = 0;
   logic [3:0]  m_ctag = 0;
   logic [31:0] m_cval = 0, m_rpc = 0;
   logic [4:0]  m_crd = 0;

   always @(posedge clk) begin : model
      bit   com, full, mis;
      ent_t h, e;
      if (rst) begin
         q.delete();
         m_tail = 0; m_cv = 0; m_cst = 0; m_clr = 0;
         m_ctag = 0; m_cval = 0; m_crd = 0; m_rpc = 0;
      end else if (rdy) begin
         if (m_clr) begin
            q.delete();
            m_tail = 0; m_cv = 0; m_cst = 0; m_clr = 0;
         end else begin
            com  = (q.size() > 0) && q[0].ready;
            full = (q.size() == 16);
            if (com) h = q[0];
            foreach (q[i]) begin
               if (slb_valid && q[i].tag == slb_tag && !(rs_valid && rs_tag == slb_tag)) begin
                  q[i].value = slb_value;
                  q[i].ready = 1'b1;
               end
               if (rs_valid && q[i].tag == rs_tag) begin
                  q[i].value = rs_value;
                  q[i].ready = 1'b1;
                  if (rs_jump_valid) q[i].jumppc = rs_jumppc;
               end
            end
            if (alloc_valid && !full) begin
               e.tag = m_tail; e.kind = alloc_kind; e.rd = alloc_rd;
               e.pred = alloc_pred_taken; e.target = alloc_target;
               e.value = 0; e.jumppc = 0; e.ready = 1'b0;
               q.push_back(e);
               m_tail = m_tail + 4'd1;
            end
            if (com) begin
               void'(q.pop_front());
               m_cv = 1; m_ctag = h.tag; m_cval = h.value; m_crd = h.rd;
               m_cst = (h.kind == 2'd3);
               mis = (h.kind == 2'd1 && h.value[0] != h.pred) ||
                     (h.kind == 2'd2 && h.jumppc != h.target);
               m_clr = mis;
               if (mis) m_rpc = (h.kind == 2'd1) ? h.target : h.jumppc;
            end else begin
               m_cv = 0; m_cst = 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("commit_valid", {31'd0, commit_valid}, {31'd0, m_cv});
         chk("commit_store", {31'd0, commit_store}, {31'd0, m_cst});
         chk("Clear_flag", {31'd0, Clear_flag}, {31'd0, m_clr});
         chk("commit_tag", {28'd0, commit_tag}, {28'd0, m_ctag});
         chk("commit_value", commit_value, m_cval);
         chk("commit_rd", {27'd0, commit_rd}, {27'd0, m_crd});
         chk("redirect_pc", redirect_pc, m_rpc);
         chk("alloc_tag", {28'd0, alloc_tag}, {28'd0, m_tail});
         chk("rob_full", {31'd0, rob_full}, {31'd0, q.size() == 16});
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
      alloc_valid = 0; rs_valid = 0; rs_jump_valid = 0; slb_valid = 0;
   endtask

   task automatic do_reset();
      rst = 1; cyc(); cyc(); rst = 0;
   endtask

   task automatic alloc(input logic [1:0] k, input logic [4:0] r, input logic p,
                        input logic [31:0] t);
      alloc_valid = 1; alloc_kind = k; alloc_rd = r; alloc_pred_taken = p; alloc_target = t;
   endtask

   task automatic rs(input logic [3:0] t, input logic [31:0] v);
      rs_valid = 1; rs_tag = t; rs_value = v;
   endtask

   task automatic slb(input logic [3:0] t, input logic [31:0] v);
      slb_valid = 1; slb_tag = t; slb_value = v;
   endtask

   task automatic expect_commit(input string nm, input logic [3:0] t, input logic [31:0] v,
                                input logic [4:0] r, input logic st, input logic cl);
      chk({nm, ".valid"}, {31'd0, commit_valid}, 32'd1);
      chk({nm, ".tag"}, {28'd0, commit_tag}, {28'd0, t});
      chk({nm, ".value"}, commit_value, v);
      chk({nm, ".rd"}, {27'd0, commit_rd}, {27'd0, r});
      chk({nm, ".store"}, {31'd0, commit_store}, {31'd0, st});
      chk({nm, ".clear"}, {31'd0, Clear_flag}, {31'd0, cl});
   endtask

   initial begin
      rst = 1; rdy = 1;
      alloc_valid = 0; alloc_kind = 0; alloc_rd = 0; alloc_pred_taken = 0; alloc_target = 0;
      rs_valid = 0; rs_tag = 0; rs_value = 0; rs_jump_valid = 0; rs_jumppc = 0;
      slb_valid = 0; slb_tag = 0; slb_value = 0;
      do_reset();
      chk_en = 1;
      chk("reset.commit_valid", {31'd0, commit_valid}, 32'd0);
      chk("reset.alloc_tag", {28'd0, alloc_tag}, 32'd0);
      chk("reset.rob_full", {31'd0, rob_full}, 32'd0);
      chk("reset.redirect_pc", redirect_pc, 32'd0);

      // In-order retirement of out-of-order completions.
      alloc(0, 1, 0, 0); cyc();
      alloc(0, 2, 0, 0); cyc();
      alloc(0, 3, 0, 0); cyc();
      rs(2, 32'hA); cyc();
      rs(0, 32'hB); cyc();
      rs(1, 32'hC); cyc();
      expect_commit("c0", 0, 32'hB, 1, 0, 0);
      cyc(); expect_commit("c1", 1, 32'hC, 2, 0, 0);
      cyc(); expect_commit("c2", 2, 32'hA, 3, 0, 0);
      cyc(); chk("c3.idle", {31'd0, commit_valid}, 32'd0);

      // Full buffer, ignored request, wrap of the tail.
      do_reset();
      for (int i = 0; i < 16; i++) begin
         alloc(0, 5'(i + 1), 0, 0); cyc();
      end
      chk("full.rob_full", {31'd0, rob_full}, 32'd1);
      chk("full.alloc_tag", {28'd0, alloc_tag}, 32'd0);
      alloc(0, 9, 0, 0); cyc();
      chk("full.ignored_tag", {28'd0, alloc_tag}, 32'd0);
      rs(0, 32'h100); cyc(); cyc();
      expect_commit("full.c", 0, 32'h100, 1, 0, 0);
      chk("full.dropped", {31'd0, rob_full}, 32'd0);
      chk("full.wrap_tag", {28'd0, alloc_tag}, 32'd0);
      alloc(0, 17, 0, 0); cyc();
      chk("full.after_wrap", {28'd0, alloc_tag}, 32'd1);
      chk("full.refull", {31'd0, rob_full}, 32'd1);

      // Mispredicted branch flushes younger ready entries.
      do_reset();
      alloc(1, 0, 1, 32'h1000); cyc();
      alloc(0, 5, 0, 0); cyc();
      rs(1, 32'h55); cyc();
      rs(0, 32'h0); cyc();
      cyc();
      expect_commit("br", 0, 32'h0, 0, 0, 1);
      chk("br.redirect", redirect_pc, 32'h1000);
      alloc(0, 6, 0, 0); cyc();
      chk("br.flushed_clear", {31'd0, Clear_flag}, 32'd0);
      chk("br.flushed_tag", {28'd0, alloc_tag}, 32'd0);
      cyc(); cyc();
      chk("br.no_younger", {31'd0, commit_valid}, 32'd0);

      // JALR mispredict, then JALR with correct prediction.
      alloc(2, 1, 0, 32'h200); cyc();
      rs(0, 32'h18); rs_jump_valid = 1; rs_jumppc = 32'h204; cyc();
      cyc();
      expect_commit("jalr", 0, 32'h18, 1, 0, 1);
      chk("jalr.redirect", redirect_pc, 32'h204);
      cyc();
      alloc(2, 1, 0, 32'h200); cyc();
      rs(0, 32'h20); rs_jump_valid = 1; rs_jumppc = 32'h200; cyc();
      cyc();
      expect_commit("jalr_ok", 0, 32'h20, 1, 0, 0);

      // Store retirement and dual completion ports.
      alloc(3, 7, 0, 0); cyc();
      alloc(0, 4, 0, 0); cyc();
      alloc(0, 6, 0, 0); cyc();
      slb(1, 32'h0); rs(2, 32'h44); cyc();
      cyc(); expect_commit("st", 1, 32'h0, 7, 1, 0);
      cyc(); expect_commit("dual", 2, 32'h44, 4, 0, 0);
      rs(3, 32'h66); slb(3, 32'h77); cyc();
      cyc(); expect_commit("rs_wins", 3, 32'h66, 6, 0, 0);

      // Stall with rdy low right after a commit pulse.
      alloc(0, 8, 0, 0); cyc();
      alloc(0, 9, 0, 0); cyc();
      rs(4, 32'h88); cyc();
      cyc(); expect_commit("pre_stall", 4, 32'h88, 8, 0, 0);
      rdy = 0;
      for (int i = 0; i < 5; i++) begin
         rs(5, 32'h99); alloc(0, 10, 0, 0); cyc();
         chk("stall.held_valid", {31'd0, commit_valid}, 32'd1);
         chk("stall.held_tag", {28'd0, commit_tag}, 32'd4);
         chk("stall.alloc_tag", {28'd0, alloc_tag}, 32'd6);
      end
      rdy = 1;
      cyc(); chk("stall.resume_idle", {31'd0, commit_valid}, 32'd0);
      rs(5, 32'h99); cyc();
      cyc(); expect_commit("post_stall", 5, 32'h99, 9, 0, 0);

      // Correctly predicted not-taken branch: no flush.
      alloc(1, 0, 0, 32'h40); cyc();
      rs(6, 32'h0); cyc();
      cyc(); expect_commit("br_ok", 6, 32'h0, 0, 0, 0);
      cyc(); cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
